// File: rtl/mem_bus_master.sv
// mem_bus_master: one CPU load/store -> one cycle on the shared memory switch bus.
// Optional stall/timeout support is enabled with `define MEM_BUS_WAIT_EN.
module mem_bus_master #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int READ_WAIT = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_address,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic              bus_load_enable,
    output logic              bus_output_enable,
    input  logic              bus_match_any
`ifdef MEM_BUS_WAIT_EN
    ,
    input  logic              bus_wait
`endif
);

    localparam int CNT_W = $clog2(READ_WAIT + 1);

    if (READ_WAIT < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("mem_bus_master: READ_WAIT must be >=1, TIMEOUT 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  rd_cnt;
    logic              accept;
    logic              rd_last;
    logic              hold;
    logic              tmo;

    assign accept  = req_valid & req_ready;
    assign rd_last = (rd_cnt == CNT_W'(READ_WAIT));

`ifdef MEM_BUS_WAIT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    logic [7:0] stall_q;

    assign hold = bus_wait & ((state == WRITE) | (state == READ));
    assign tmo  = hold & ((stall_q + 8'd1) == TMO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (hold) begin
            stall_q <= stall_q + 8'd1;
        end
    end
`else
    assign hold = 1'b0;
    assign tmo  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = req_write ? WRITE : READ;
            WRITE: if (tmo || !hold) state_nx = RESP;
            READ:  if (tmo || (!hold && rd_last)) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
                rd_cnt  <= '0;
            end
            if (state == WRITE) begin
                err_q <= tmo | ~bus_match_any;
            end
            if (state == READ) begin
                if (rd_cnt == '0) err_q <= ~bus_match_any;
                if (!hold) begin
                    if (rd_last) rdata_q <= bus_data;
                    else         rd_cnt  <= rd_cnt + 1'b1;
                end
                // a timeout overrides whatever match was seen
                if (tmo) err_q <= 1'b1;
            end
        end
    end

    assign req_ready         = reset & (state == IDLE);
    assign rsp_valid         = (state == RESP);
    assign rsp_err           = (state == RESP) & err_q;
    assign rsp_rdata         = ((state == RESP) && !err_q) ? rdata_q : '0;
    assign bus_address       = addr_q;
    assign bus_load_enable   = (state == WRITE);
    assign bus_output_enable = (state == READ);
    assign bus_data          = (state == WRITE) ? wdata_q : 'z;

endmodule
